instr_encode_loader: RTL and testbench
======================================

Name: instr_encode_loader

Overview:
- Encoder/loader that sits ahead of instruction memory and produces the 32-bit RV32I words the decode stage consumes.
- Accepts decoded instruction fields over a valid/ready stream and encodes R-type, I-type ALU, LW and SW words.
- Writes the words to consecutive word addresses of instruction memory, starting at a programmed base.
- Used by the bench and by boot logic to load programs.

Parameters:
- ADDR_W, 10, instruction-memory byte-address width.
- CNT_W, 9, width of instruction count and error counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle pulse; begins a load session. Honoured only in IDLE or DONE.
- base_addr  in  ADDR_W  first byte address. Bits [1:0] are ignored and forced to 0.
- num_instr  in  CNT_W  number of instructions in the session.
- in_valid  in  1  field tuple valid.
- in_ready  out  1  encoder can accept a tuple.
- in_class  in  2  00=R (0110011), 01=I-ALU (0010011), 10=LW (0000011), 11=SW (0100011).
- in_rd, in_rs1, in_rs2  in  5 each  register fields.
- in_funct3  in  3  funct3; used for R and I-ALU only.
- in_funct7  in  7  funct7; used for R only.
- in_imm  in  32  signed immediate; used for I-ALU, LW and SW.
- mem_we  out  1  instruction-memory write strobe.
- mem_addr  out  ADDR_W  write byte address.
- mem_wdata  out  32  encoded word.
- busy  out  1  high in LOAD or FLUSH.
- done  out  1  high in DONE.
- err  out  1  sticky immediate-range error.
- err_count  out  CNT_W  count of substituted instructions; saturates at all-ones.

Behaviour:
- One clock. Reset is synchronous and active-low: rst_n low at a rising clk edge forces state IDLE and zeroes all registered outputs. mem_we, mem_addr, mem_wdata, err and err_count become 0; in_ready, busy and done read 0.
- State machine:
  - IDLE: start -> LOAD. Latch base_addr and num_instr, clear err and err_count. If num_instr==0, go to DONE instead.
  - LOAD: in_ready = 1. On each accepted tuple (in_valid & in_ready at the edge), decrement remaining. The accept that brings remaining to 0 moves to FLUSH.
  - FLUSH: in_ready = 0. Exactly one cycle, during which the last mem_we is presented; then DONE.
  - DONE: done = 1, holds. start re-enters LOAD (or DONE directly if num_instr==0) with the same latching as IDLE. start in LOAD or FLUSH is ignored.
- Latency: a tuple accepted at edge t produces mem_we=1 with mem_addr/mem_wdata valid for the cycle after t. Exactly one write per accept. mem_we is 0 in every other cycle.
- Addressing:
  - First write goes to base_addr; each later write goes to the previous address +4.
  - The address wraps modulo 2^ADDR_W, with no error.
  - Substituted instructions consume a slot and advance the address.
- Encoding:
  - R: {funct7, rs2, rs1, funct3, rd, 0110011}.
  - I-ALU: {imm[11:0], rs1, funct3, rd, 0010011}.
  - LW: {imm[11:0], rs1, 010, rd, 0000011}; in_funct3 is ignored.
  - SW: {imm[11:5], rs2, rs1, 010, imm[4:0], 0100011}; in_funct3 and in_rd are ignored.
- Range rule: for I-ALU, LW and SW, in_imm must lie in -2048..2047 (bits [31:11] all equal). If it does not:
  - write NOP 0x00000013 in that slot;
  - set err;
  - increment err_count.
  - R-type never errors.
- Simultaneous events: rst_n low wins over start and over a pending accept. Reset mid-session aborts the session and suppresses the pending write.
- Tuples presented outside LOAD are not consumed (in_ready=0).

Optional Feature:
- Macro: INSTR_LOAD_CHECKSUM_EN.
- When defined:
  - adds output port chk (32 bits);
  - chk is cleared on start and on reset;
  - chk is XORed with mem_wdata on every cycle mem_we=1;
  - chk is stable and final in DONE.
- When undefined: the port and the logic are absent. All other behaviour is identical.

Test Plan:
- base 0x000, n=1, R rd=3 rs1=1 rs2=2 f3=0 f7=0 -> mem_we one cycle after accept, addr 0x000, data 0x002081B3, FLUSH then done=1.
- I-ALU rd=5 rs1=0 f3=0 imm=-1 -> 0xFFF00293. LW rd=6 rs1=2 imm=8 with in_funct3=7 -> 0x00812303. SW rs2=7 rs1=2 imm=-4 -> 0xFE712E23. Addresses +4 each.
- I-ALU imm=2048, then SW imm=-2049 -> both slots 0x00000013, err=1, err_count=2. The next start clears both.
- ADDR_W=10, base 0x3F9, n=3, in_valid toggling every other cycle -> writes at 0x3F8, 0x3FC, 0x000. Exactly 3 mem_we pulses. in_ready=0 after the third accept.
- num_instr=0 -> DONE the cycle after start with no mem_we. start pulsed during LOAD -> ignored, count unchanged.
- rst_n low one cycle after an accept in LOAD -> no mem_we follows, state IDLE, all outputs 0. With INSTR_LOAD_CHECKSUM_EN, words from scenario 2 -> chk = 0xFFF00293 ^ 0x00812303 ^ 0xFE712E23.

Source files
------------

// File: rtl/instr_encode_loader.sv
// RV32I encoder/loader: encodes field tuples and writes them to instruction memory.
// Optional running XOR checksum output when INSTR_LOAD_CHECKSUM_EN is defined.
module instr_encode_loader #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_instr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_class,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  err_count
`ifdef INSTR_LOAD_CHECKSUM_EN
    ,
    output logic [31:0]       chk
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_DONE
    } state_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    state_t state;
    state_t state_nx;

    logic              go;
    logic              accept;
    logic [CNT_W-1:0]  remaining;
    logic [ADDR_W-1:0] wr_ptr;
    logic [31:0]       enc_word;
    logic              enc_err;
    logic              imm_ok;

    // Control FSM: start is only honoured when no session is in flight.
    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        go       = 1'b0;
        accept   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    go       = 1'b1;
                    state_nx = (num_instr == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                accept   = in_valid;
                if (in_valid && remaining == CNT_W'(1)) begin
                    state_nx = S_FLUSH;
                end
            end
            S_FLUSH: begin
                busy     = 1'b1;
                state_nx = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    go       = 1'b1;
                    state_nx = (num_instr == '0) ? S_DONE : S_LOAD;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Immediate fits in 12 signed bits when bits [31:11] are all equal.
    always_comb begin
        imm_ok   = (&in_imm[31:11]) | ~(|in_imm[31:11]);
        enc_word = NOP;
        enc_err  = 1'b0;
        unique case (in_class)
            2'b00: begin
                enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, OP_R};
            end
            2'b01: begin
                if (imm_ok) begin
                    enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_IALU};
                end else begin
                    enc_err = 1'b1;
                end
            end
            2'b10: begin
                if (imm_ok) begin
                    enc_word = {in_imm[11:0], in_rs1, 3'b010, in_rd, OP_LW};
                end else begin
                    enc_err = 1'b1;
                end
            end
            2'b11: begin
                if (imm_ok) begin
                    enc_word = {in_imm[11:5], in_rs2, in_rs1, 3'b010,
                                in_imm[4:0], OP_SW};
                end else begin
                    enc_err = 1'b1;
                end
            end
            default: enc_word = NOP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Write port is registered: one write in the cycle after each accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            remaining <= '0;
            wr_ptr    <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            err       <= 1'b0;
            err_count <= '0;
        end else begin
            mem_we <= 1'b0;
            if (go) begin
                remaining <= num_instr;
                wr_ptr    <= base_addr & ~ADDR_W'(3);
                err       <= 1'b0;
                err_count <= '0;
            end
            if (accept) begin
                mem_we    <= 1'b1;
                mem_addr  <= wr_ptr;
                mem_wdata <= enc_word;
                wr_ptr    <= wr_ptr + ADDR_W'(4);
                remaining <= remaining - CNT_W'(1);
                if (enc_err) begin
                    err <= 1'b1;
                    if (err_count != '1) begin
                        err_count <= err_count + CNT_W'(1);
                    end
                end
            end
        end
    end

`ifdef INSTR_LOAD_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chk <= '0;
        end else if (go) begin
            chk <= '0;
        end else if (mem_we) begin
            chk <= chk ^ mem_wdata;
        end
    end
`endif

endmodule

// File: tb/tb_instr_encode_loader.sv
// Scoreboard bench for instr_encode_loader: directed tuples, queued expected writes.
// Checks chk too when INSTR_LOAD_CHECKSUM_EN is defined.
module tb_instr_encode_loader;

    localparam int ADDR_W = 10;
    localparam int CNT_W  = 9;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  num_instr;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_class;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [2:0]        in_funct3;
    logic [6:0]        in_funct7;
    logic [31:0]       in_imm;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic [CNT_W-1:0]  err_count;
`ifdef INSTR_LOAD_CHECKSUM_EN
    logic [31:0]       chk;
`endif

    instr_encode_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .num_instr (num_instr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_class  (in_class),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_imm    (in_imm),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_count (err_count)
`ifdef INSTR_LOAD_CHECKSUM_EN
        ,
        .chk       (chk)
`endif
    );

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  writes = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every presented write must match the head of the queue.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_t e;
            writes++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%h data=%h, required no write",
                         mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                if (mem_addr !== e.addr || mem_wdata !== e.data) begin
                    errors++;
                    $display("FAIL write: got addr=%h data=%h, required addr=%h data=%h",
                             mem_addr, mem_wdata, e.addr, e.data);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic start_session(input logic [ADDR_W-1:0] b,
                                 input logic [CNT_W-1:0] n);
        @(negedge clk);
        base_addr = b;
        num_instr = n;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic send(input logic [1:0] cls, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm,
                        input logic [ADDR_W-1:0] ea, input logic [31:0] ed);
        int n;
        wr_t e;
        in_class  = cls;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct3 = f3;
        in_funct7 = f7;
        in_imm    = imm;
        in_valid  = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=%b, required 1", in_ready);
        end else begin
            e.addr = ea;
            e.data = ed;
            exp_q.push_back(e);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("done_reached", {31'd0, done}, 32'd1);
    endtask

    int w0;

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        num_instr = '0;
        in_valid  = 1'b0;
        in_class  = '0;
        in_rd     = '0;
        in_rs1    = '0;
        in_rs2    = '0;
        in_funct3 = '0;
        in_funct7 = '0;
        in_imm    = '0;
        repeat (3) @(negedge clk);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_flags", {28'd0, in_ready, busy, done, err}, 32'd0);
        check("rst_err_count", {23'd0, err_count}, 32'd0);
        rst_n = 1'b1;

        // One R-type word, then FLUSH and DONE.
        start_session(10'h000, 9'd1);
        send(2'b00, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 10'h000, 32'h002081B3);
        check("flush_busy", {30'd0, busy, in_ready}, 32'd2);
        check("flush_we", {31'd0, mem_we}, 32'd1);
        @(posedge clk);
        #1;
        check("s1_done", {30'd0, done, mem_we}, 32'd2);

        // I-ALU, LW with ignored funct3, SW with ignored rd.
        start_session(10'h100, 9'd3);
        send(2'b01, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 10'h100, 32'hFFF00293);
        send(2'b10, 5'd6, 5'd2, 5'd0, 3'd7, 7'd0, 32'd8, 10'h104, 32'h00812303);
        send(2'b11, 5'd9, 5'd2, 5'd7, 3'd0, 7'd0, 32'hFFFFFFFC, 10'h108, 32'hFE712E23);
        wait_done();
        check("s2_err", {31'd0, err}, 32'd0);
`ifdef INSTR_LOAD_CHECKSUM_EN
        check("s2_chk", chk, 32'hFFF00293 ^ 32'h00812303 ^ 32'hFE712E23);
`endif

        // Out-of-range immediates become NOPs and are counted.
        start_session(10'h040, 9'd2);
        send(2'b01, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd2048, 10'h040, 32'h00000013);
        send(2'b11, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFF7FF, 10'h044, 32'h00000013);
        wait_done();
        check("s3_err", {31'd0, err}, 32'd1);
        check("s3_err_count", {23'd0, err_count}, 32'd2);

        // Empty session: DONE right away, flags cleared, no writes.
        w0 = writes;
        start_session(10'h080, 9'd0);
        check("s5_zero_done", {31'd0, done}, 32'd1);
        check("s5_err_clear", {22'd0, err, err_count}, 32'd0);
        repeat (3) @(negedge clk);
        check("s5_no_writes", writes - w0, 32'd0);

        // Unaligned base near the top, valid toggling, address wraps.
        w0 = writes;
        start_session(10'h3F9, 9'd3);
        send(2'b00, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'd0, 10'h3F8, 32'h403100B3);
        @(posedge clk);
        #1;
        send(2'b00, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'd0, 10'h3FC, 32'h403100B3);
        @(posedge clk);
        #1;
        send(2'b00, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'd0, 10'h000, 32'h403100B3);
        check("s4_ready_low", {31'd0, in_ready}, 32'd0);
        wait_done();
        repeat (2) @(negedge clk);
        check("s4_pulses", writes - w0, 32'd3);

        // start during LOAD is ignored.
        w0 = writes;
        start_session(10'h200, 9'd2);
        send(2'b00, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 10'h200, 32'h002081B3);
        start_session(10'h300, 9'd5);
        check("s5_start_ignored", {31'd0, busy}, 32'd1);
        send(2'b00, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 10'h204, 32'h002081B3);
        wait_done();
        repeat (2) @(negedge clk);
        check("s5_count", writes - w0, 32'd2);

        // Reset mid-session suppresses the pending accept.
        w0 = writes;
        start_session(10'h000, 9'd3);
        send(2'b01, 5'd4, 5'd1, 5'd0, 3'd0, 7'd0, 32'd5000, 10'h000, 32'h00000013);
        check("s6_err_set", {31'd0, err}, 32'd1);
        @(negedge clk);
        in_class = 2'b00;
        in_valid = 1'b1;
        rst_n    = 1'b0;
        @(posedge clk);
        #1;
        check("s6_rst_outs", {29'd0, mem_we, err, busy}, 32'd0);
        check("s6_rst_addr", {22'd0, mem_addr}, 32'd0);
        check("s6_rst_data", mem_wdata, 32'd0);
        check("s6_rst_ctl", {23'd0, err_count} | {29'd0, in_ready, done, 1'b0}, 32'd0);
`ifdef INSTR_LOAD_CHECKSUM_EN
        check("s6_rst_chk", chk, 32'd0);
`endif
        in_valid = 1'b0;
        rst_n    = 1'b1;
        repeat (4) @(negedge clk);
        check("s6_one_write", writes - w0, 32'd1);
        check("s6_idle", {30'd0, busy, done}, 32'd0);

        check("queue_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
